// File: rtl/mem_io_responder.sv
// mem_io_responder
//   Memory-side responder for the CPU bus. It serves loads and stores from
//   on-chip RAM and from a small memory-mapped I/O window:
//     IO_BASE+0  SW    read-only, debounced switch state
//     IO_BASE+1  LED   read/write, drives the board LEDs
//     IO_BASE+2  EDGE  rising-edge capture of SW; write 1 to clear a bit
//   Loads have a latency of one cycle. Stores take effect on the edge that
//   samples them.
// Ports
//   clk     in   system clock
//   reset   in   asynchronous active-high reset
//   addr    in   word address from the CPU
//   wdata   in   store data
//   we      in   store strobe (one cycle per store)
//   re      in   load strobe (one cycle per load)
//   rdata   out  load data, valid while rvalid is high
//   rvalid  out  one-cycle pulse marking load data
//   sw      in   raw asynchronous board switches
//   leds    out  LED drive
module mem_io_responder #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 16,
  parameter int RAM_ADDR_BITS   = 13,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE = 16'hFF00,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  input  logic [9:0]            sw,
  output logic [9:0]            leds
);

  localparam int RAM_WORDS = 2 ** RAM_ADDR_BITS;
  localparam int CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [ADDR_WIDTH-1:0] SW_ADDR   = IO_BASE;
  localparam logic [ADDR_WIDTH-1:0] LED_ADDR  = ADDR_WIDTH'(IO_BASE + 1);
  localparam logic [ADDR_WIDTH-1:0] EDGE_ADDR = ADDR_WIDTH'(IO_BASE + 2);

  // RAM storage; intentionally not reset.
  logic [DATA_WIDTH-1:0] mem [0:RAM_WORDS-1];

  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q;
  logic [9:0]            leds_q, leds_d;
  logic [9:0]            sync1_q, sync2_q;
  logic [9:0]            stable_q, stable_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [9:0]            edge_q, edge_d;

  logic ram_sel, sw_sel, led_sel, edge_sel;
  logic [RAM_ADDR_BITS-1:0] ram_idx;

  assign ram_sel  = (addr[ADDR_WIDTH-1:RAM_ADDR_BITS] == '0);
  assign sw_sel   = (addr == SW_ADDR);
  assign led_sel  = (addr == LED_ADDR);
  assign edge_sel = (addr == EDGE_ADDR);
  assign ram_idx  = addr[RAM_ADDR_BITS-1:0];

  // Load data mux. All sources are pre-edge values, so a store to the same
  // address in the same cycle is seen only by later loads (read-first).
  always_comb begin
    rdata_d = '0;
    if (ram_sel) begin
      rdata_d = mem[ram_idx];
    end else if (sw_sel) begin
      rdata_d[9:0] = stable_q;
    end else if (led_sel) begin
      rdata_d[9:0] = leds_q;
    end else if (edge_sel) begin
      rdata_d[9:0] = edge_q;
    end
  end

  // LED register next state.
  always_comb begin
    leds_d = leds_q;
    if (we && led_sel) begin
      leds_d = wdata[9:0];
    end
  end

  // Debouncer: one shared counter for the whole switch vector. It runs while
  // the synced value differs from the stable value and commits on reaching
  // the last count; any return to equality restarts it.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Edge capture: the set is taken from the stable value being committed on
  // this edge, and applied after the clear so a simultaneous set wins.
  always_comb begin
    edge_d = edge_q;
    if (we && edge_sel) begin
      edge_d = edge_d & ~wdata[9:0];
    end
    edge_d = edge_d | (stable_d & ~stable_q);
  end

  always_ff @(posedge clk) begin
    if (we && ram_sel) begin
      mem[ram_idx] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      leds_q   <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      edge_q   <= '0;
    end else begin
      rvalid_q <= re;
      if (re) begin
        rdata_q <= rdata_d;
      end
      leds_q   <= leds_d;
      sync1_q  <= sw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign leds   = leds_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder
//   Directed test of mem_io_responder with default parameters
//   (DEBOUNCE_CYCLES = 16, IO window at 0xFF00).
module tb_mem_io_responder;

  localparam int DB = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        we;
  logic        re;
  logic [15:0] rdata;
  logic        rvalid;
  logic [9:0]  sw;
  logic [9:0]  leds;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  mem_io_responder #(
    .DATA_WIDTH     (16),
    .ADDR_WIDTH     (16),
    .RAM_ADDR_BITS  (13),
    .IO_BASE        (16'hFF00),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .re    (re),
    .rdata (rdata),
    .rvalid(rvalid),
    .sw    (sw),
    .leds  (leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are then sampled and inputs changed 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic do_store(input logic [15:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] a, output logic [15:0] d, output logic v);
    addr = a;
    re   = 1'b1;
    tick();
    d    = rdata;
    v    = rvalid;
    re   = 1'b0;
  endtask

  logic [15:0] d;
  logic        v;

  initial begin
    reset = 1'b1;
    addr  = '0;
    wdata = '0;
    we    = 1'b0;
    re    = 1'b0;
    sw    = '0;
    ticks(3);
    check("reset_rvalid", {15'b0, rvalid}, 16'h0000);
    check("reset_rdata",  rdata, 16'h0000);
    check("reset_leds",   {6'b0, leds}, 16'h0000);
    reset = 1'b0;
    tick();

    // 1: RAM store/load, one-cycle rvalid
    do_store(16'h0010, 16'hBEEF);
    do_load(16'h0010, d, v);
    check("ram_load_data",  d, 16'hBEEF);
    check("ram_load_valid", {15'b0, v}, 16'h0001);
    tick();
    check("rvalid_one_cycle", {15'b0, rvalid}, 16'h0000);

    // 2: LED register
    do_store(16'hFF01, 16'hFFFF);
    check("leds_after_ffff", {6'b0, leds}, 16'h03FF);
    do_load(16'hFF01, d, v);
    check("led_readback", d, 16'h03FF);
    do_store(16'hFF01, 16'h0005);
    check("leds_after_5", {6'b0, leds}, 16'h0005);

    // 3: unmapped accesses, SW write ignored
    do_store(16'h0000, 16'hAAAA);
    do_load(16'h4000, d, v);
    check("unmapped_data",  d, 16'h0000);
    check("unmapped_valid", {15'b0, v}, 16'h0001);
    do_store(16'h4000, 16'h1234);
    do_store(16'hFF00, 16'h03FF);
    do_load(16'h0000, d, v);
    check("ram0_unaliased", d, 16'hAAAA);
    do_load(16'h0010, d, v);
    check("ram10_unchanged", d, 16'hBEEF);
    check("leds_unchanged", {6'b0, leds}, 16'h0005);
    do_load(16'hFF00, d, v);
    check("sw_ro", d, 16'h0000);
    do_load(16'h1FFF, d, v);
    check("ram_top_valid", {15'b0, v}, 16'h0001);

    // 4: debounce. Glitch of DB-2 cycles is rejected.
    sw = 10'h001;
    ticks(DB - 2);
    sw = 10'h000;
    ticks(24);
    do_load(16'hFF00, d, v);
    check("glitch_sw", d, 16'h0000);
    do_load(16'hFF02, d, v);
    check("glitch_edge", d, 16'h0000);
    // Clean change: stable updates on the 2+DB-th edge after the change.
    sw = 10'h001;
    ticks(2 + DB - 1);
    do_load(16'hFF00, d, v);      // edge 2+DB samples pre-edge value
    check("sw_before_latency", d, 16'h0000);
    do_load(16'hFF00, d, v);
    check("sw_after_latency", d, 16'h0001);
    do_load(16'hFF02, d, v);
    check("edge_set", d, 16'h0001);

    // 5: EDGE clear and set-wins
    do_store(16'hFF02, 16'h0001);
    do_load(16'hFF02, d, v);
    check("edge_cleared", d, 16'h0000);
    sw = 10'h000;
    ticks(30);
    do_load(16'hFF02, d, v);
    check("edge_no_fall", d, 16'h0000);
    sw = 10'h001;
    ticks(2 + DB - 1);
    do_store(16'hFF02, 16'h0001); // clear lands on the rising edge
    do_load(16'hFF02, d, v);
    check("edge_set_wins", d, 16'h0001);
    do_load(16'hFF02, d, v);
    check("edge_read_no_clear", d, 16'h0001);

    // 6: read-first on same-cycle re+we
    do_store(16'h0020, 16'h1111);
    addr  = 16'h0020;
    wdata = 16'h2222;
    we    = 1'b1;
    re    = 1'b1;
    tick();
    d = rdata;
    v = rvalid;
    we = 1'b0;
    re = 1'b0;
    check("read_first_data",  d, 16'h1111);
    check("read_first_valid", {15'b0, v}, 16'h0001);
    do_load(16'h0020, d, v);
    check("after_write_data", d, 16'h2222);

    // Reset with a response on the bus
    addr = 16'h0020;
    re   = 1'b1;
    tick();
    re   = 1'b0;
    check("pending_valid", {15'b0, rvalid}, 16'h0001);
    reset = 1'b1;
    #1;
    check("reset_mid_rvalid", {15'b0, rvalid}, 16'h0000);
    check("reset_mid_leds",   {6'b0, leds}, 16'h0000);
    check("reset_mid_rdata",  rdata, 16'h0000);
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_rvalid", {15'b0, rvalid}, 16'h0000);
    do_load(16'hFF00, d, v);
    check("post_reset_sw", d, 16'h0000);
    do_load(16'hFF02, d, v);
    check("post_reset_edge", d, 16'h0000);
    do_load(16'h0020, d, v);
    check("ram_survives_reset", d, 16'h2222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
